interval_timer: RTL and testbench
=================================

// Module: interval_timer
// PURPOSE
//  Parametrised start/stop interval timer. Successor to the single-width start/stop counter FSM.
//  Adds: configurable width; prescaled tick; pause; restart while running;
//  overflow policy; result held under a valid/ready handshake.
//  Sits between control logic (start/stop/pause pulses) and a result consumer.
// PARAMETERS
//  WIDTH     8  bits of the interval counter and count_o
//  PRESCALE  1  clock cycles per counted tick (>=1; 1 = count every RUN cycle)
//  SATURATE  0  overflow policy: 0 = wrap to 0, 1 = hold at 2**WIDTH-1
// PORTS
//  clk_i    in   1      clock, all logic on rising edge
//  rst_i    in   1      synchronous reset, active-high
//  start_i  in   1      start / restart measurement (sampled each cycle)
//  stop_i   in   1      end measurement, publish result
//  pause_i  in   1      level: high freezes counting while measuring
//  ready_i  in   1      consumer accepts result when valid_o && ready_i
//  count_o  out  WIDTH  result register, stable while valid_o=1
//  ovf_o    out  1      overflow occurred during the reported measurement (qualified by valid_o)
//  valid_o  out  1      result available
//  busy_o   out  1      1 in RUN or PAUSE
// BEHAVIOUR
//  Reset: state=IDLE; count_o=0, ovf_o=0, valid_o=0, busy_o=0; counter and prescaler=0.
//   Reset mid-measurement or mid-handshake discards everything; the result is not published.
//  States: IDLE, RUN, PAUSE, REPORT. All outputs are registered.
//  IDLE:   start_i -> RUN. Counter=0, prescaler=0, ovf flag=0. stop_i/pause_i/ready_i ignored.
//  RUN:    Priority order:
//   - stop_i  -> REPORT.
//   - start_i -> RUN. Restart: counter, prescaler and ovf are cleared.
//   - pause_i -> PAUSE.
//   - else: prescaler advances; counter increments on tick.
//  PAUSE:  Priority order:
//   - stop_i  -> REPORT.
//   - start_i -> RUN (restart).
//   - !pause_i -> RUN.
//   - else: hold counter and prescaler.
//  REPORT: valid_o=1, count_o and ovf_o frozen.
//   - ready_i && start_i -> RUN (new measurement, cleared).
//   - ready_i -> IDLE.
//   - else: remain; start_i/stop_i are ignored without ready_i.
//  Stop cycle: the cycle in which stop_i is sampled is not counted.
//   count_o = counter register value at that edge.
//   valid_o rises on the edge that samples stop_i.
//  Tick: prescaler counts 0..PRESCALE-1; tick when prescaler==PRESCALE-1 in a RUN cycle, then wraps to 0.
//   The first tick is PRESCALE RUN cycles after start.
//  Overflow: increment from 2**WIDTH-1 sets the sticky ovf flag.
//   SATURATE=0: counter goes to 0. SATURATE=1: counter holds at max.
//  busy_o is the registered decode of RUN|PAUSE. valid_o is the registered decode of REPORT.
// STRUCTURE
//  Package timer_pkg: localparams ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_REPORT=3; state width 2.
//  Sub-module tick_prescaler #(PRESCALE). Ports: clk_i, rst_i, clr_i, en_i, tick_o (combinational tick).
//   PRESCALE=1 degenerates to tick_o=en_i.
//  Top level holds the next-state logic, the counter, ovf, and the result/valid registers.
// TESTING
//  1. Defaults: start_i pulse at cycle 0, stop_i pulse at cycle 10, ready_i=1.
//     Expect count_o=9, ovf_o=0, valid_o high for exactly 1 cycle, then IDLE.
//  2. Pause: start at 0, pause_i high cycles 3-7, stop at 10.
//     Expect count_o=4. busy_o stays 1 throughout pause.
//  3. Overflow, WIDTH=4: start, stop 20 cycles later.
//     SATURATE=0 -> count_o=3, ovf_o=1. SATURATE=1 -> count_o=15, ovf_o=1.
//  4. PRESCALE=4: start at 0, stop at 17 -> count_o=4.
//     Restart (start_i) at cycle 9 of a run, stop at 14 -> count_o=1.
//  5. Backpressure: ready_i=0 for 5 cycles after stop.
//     Expect valid_o held and count_o stable; start_i/stop_i ignored.
//     Then ready_i && start_i -> busy_o=1 next cycle, valid_o=0.
//  6. rst_i pulse during RUN and during REPORT: all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared state encoding and helpers for the interval timer.
package timer_pkg;

    localparam int         ST_W      = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSE  = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_RUN    = ST_RUN,
        S_PAUSE  = ST_PAUSE,
        S_REPORT = ST_REPORT
    } state_e;

    // A measurement is in progress in RUN and in PAUSE.
    function automatic logic is_busy(input state_e s);
        return (s == S_RUN) || (s == S_PAUSE);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick_o marks the last cycle of each group.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // Every enabled cycle is a tick; no state is needed.
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, rst_i, clr_i};
            assign tick_o        = en_i;
        end else begin : g_count
            localparam int            PW   = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] psc_q;
            logic [PW-1:0] psc_d;

            // Next prescaler value: clear wins, otherwise step and wrap on enabled cycles.
            always_comb begin
                // NOTE: default first so every path assigns psc_d and no latch is inferred.
                psc_d = psc_q;
                if (clr_i) begin
                    psc_d = '0;
                end else if (en_i) begin
                    psc_d = (psc_q == LAST) ? '0 : psc_q + PW'(1);
                end
            end

            // Prescaler register with synchronous reset.
            always_ff @(posedge clk_i) begin
                // NOTE: non-blocking so all registers update together at the edge.
                if (rst_i) psc_q <= '0;
                else       psc_q <= psc_d;
            end

            assign tick_o = en_i && (psc_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/interval_timer.sv
// Start/stop interval timer with pause, restart, overflow policy and a
// valid/ready-held result.
module interval_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] count_o,
    output logic             ovf_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic [WIDTH-1:0] count_q;
    logic             ovf_q, valid_q, busy_q;

    logic clr;      // start of a fresh measurement
    logic cnt_en;   // this cycle counts toward the prescaler
    logic load;     // publish the counter into the result register
    logic tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr),
        .en_i   (cnt_en),
        .tick_o (tick)
    );

    // Next-state decode; also decides whether this cycle clears, counts or publishes.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        cnt_en  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    clr     = 1'b1;
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    state_d = S_REPORT;
                    load    = 1'b1;
                end else if (start_i) begin
                    clr     = 1'b1;
                end else if (pause_i) begin
                    state_d = S_PAUSE;
                end else begin
                    cnt_en  = 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop_i) begin
                    state_d = S_REPORT;
                    load    = 1'b1;
                end else if (start_i) begin
                    state_d = S_RUN;
                    clr     = 1'b1;
                end else if (!pause_i) begin
                    // Pause is a level: the cycle it drops is already a counting cycle.
                    state_d = S_RUN;
                    cnt_en  = 1'b1;
                end
            end
            S_REPORT: begin
                if (ready_i) begin
                    state_d = start_i ? S_RUN : S_IDLE;
                    clr     = start_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter and sticky overflow: cleared on a new measurement, stepped on each tick.
    always_comb begin
        cnt_d      = cnt_q;
        ovf_flag_d = ovf_flag_q;
        if (clr) begin
            cnt_d      = '0;
            ovf_flag_d = 1'b0;
        end else if (tick) begin
            if (cnt_q == CNT_MAX) begin
                ovf_flag_d = 1'b1;
                cnt_d      = SATURATE ? CNT_MAX : '0;
            end else begin
                cnt_d      = cnt_q + WIDTH'(1);
            end
        end
    end

    // State, counter and registered outputs; reset drops any unpublished result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_flag_q <= ovf_flag_d;
            // The stop cycle itself is not counted: publish the pre-stop value.
            if (load) begin
                count_q <= cnt_q;
                ovf_q   <= ovf_flag_q;
            end
            valid_q    <= (state_d == S_REPORT);
            busy_q     <= is_busy(state_d);
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: four parameterisations share one stimulus.
module tb_interval_timer;

    logic clk_i = 1'b0;
    logic rst_i, start_i, stop_i, pause_i, ready_i;

    logic [7:0] d_count;  logic d_ovf,  d_valid,  d_busy;   // 8-bit, PRESCALE 1, wrap
    logic [3:0] w_count;  logic w_ovf,  w_valid,  w_busy;   // 4-bit, wrap
    logic [3:0] s_count;  logic s_ovf,  s_valid,  s_busy;   // 4-bit, saturate
    logic [7:0] p_count;  logic p_ovf,  p_valid,  p_busy;   // 8-bit, PRESCALE 4

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk_i = ~clk_i;

    interval_timer #(.WIDTH(8), .PRESCALE(1), .SATURATE(1'b0)) u_def (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .pause_i(pause_i), .ready_i(ready_i),
        .count_o(d_count), .ovf_o(d_ovf), .valid_o(d_valid), .busy_o(d_busy));

    interval_timer #(.WIDTH(4), .PRESCALE(1), .SATURATE(1'b0)) u_w4w (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .pause_i(pause_i), .ready_i(ready_i),
        .count_o(w_count), .ovf_o(w_ovf), .valid_o(w_valid), .busy_o(w_busy));

    interval_timer #(.WIDTH(4), .PRESCALE(1), .SATURATE(1'b1)) u_w4s (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .pause_i(pause_i), .ready_i(ready_i),
        .count_o(s_count), .ovf_o(s_ovf), .valid_o(s_valid), .busy_o(s_busy));

    interval_timer #(.WIDTH(8), .PRESCALE(4), .SATURATE(1'b0)) u_p4 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .pause_i(pause_i), .ready_i(ready_i),
        .count_o(p_count), .ovf_o(p_ovf), .valid_o(p_valid), .busy_o(p_busy));

    // One clock; outputs are read 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare all four outputs of one instance (0=def, 1=w4 wrap, 2=w4 sat, 3=prescale 4).
    task automatic expect_out(input string tag, input int which, input logic [31:0] c,
                              input logic o, input logic v, input logic b);
        logic [31:0] ac;
        logic        ao, av, ab;
        case (which)
            0:       begin ac = 32'(d_count); ao = d_ovf; av = d_valid; ab = d_busy; end
            1:       begin ac = 32'(w_count); ao = w_ovf; av = w_valid; ab = w_busy; end
            2:       begin ac = 32'(s_count); ao = s_ovf; av = s_valid; ab = s_busy; end
            default: begin ac = 32'(p_count); ao = p_ovf; av = p_valid; ab = p_busy; end
        endcase
        check({tag, ".count"}, ac, c);
        check({tag, ".ovf"},   32'(ao), 32'(o));
        check({tag, ".valid"}, 32'(av), 32'(v));
        check({tag, ".busy"},  32'(ab), 32'(b));
    endtask

    task automatic pulse_start();
        start_i = 1'b1; tick(); start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0; ready_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) expect_out("reset", k, 0, 1'b0, 1'b0, 1'b0);

        // 1: start at 0, stop at 10 -> 9 counted cycles; valid for one cycle only.
        pulse_start();
        expect_out("t1_start", 0, 0, 1'b0, 1'b0, 1'b1);
        repeat (9) tick();
        pulse_stop();
        expect_out("t1_stop_def", 0, 9, 1'b0, 1'b1, 1'b0);
        expect_out("t1_stop_w4",  1, 9, 1'b0, 1'b1, 1'b0);
        expect_out("t1_stop_p4",  3, 2, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("t1_idle", 0, 9, 1'b0, 1'b0, 1'b0);

        // 2: pause high during cycles 3..7, stop at 10 -> cycles 1,2,8,9 counted.
        pulse_start();
        repeat (2) tick();
        pause_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_pause_busy",  32'(d_busy),  32'd1);
            check("t2_pause_valid", 32'(d_valid), 32'd0);
        end
        pause_i = 1'b0;
        repeat (2) tick();
        pulse_stop();
        expect_out("t2_stop_def", 0, 4, 1'b0, 1'b1, 1'b0);
        expect_out("t2_stop_p4",  3, 1, 1'b0, 1'b1, 1'b0);
        tick();

        // 3: stop 20 cycles after start -> 19 counted; 4-bit wraps to 3 or saturates at 15.
        pulse_start();
        repeat (19) tick();
        pulse_stop();
        expect_out("t3_def",   0, 19, 1'b0, 1'b1, 1'b0);
        expect_out("t3_wrap",  1, 3,  1'b1, 1'b1, 1'b0);
        expect_out("t3_sat",   2, 15, 1'b1, 1'b1, 1'b0);
        expect_out("t3_p4",    3, 4,  1'b0, 1'b1, 1'b0);
        tick();

        // 4a: start at 0, stop at 17 -> 16 counted, 4 prescaled ticks; exactly 16 wraps 4-bit to 0.
        pulse_start();
        repeat (16) tick();
        pulse_stop();
        expect_out("t4_p4",   3, 4,  1'b0, 1'b1, 1'b0);
        expect_out("t4_wrap", 1, 0,  1'b1, 1'b1, 1'b0);
        expect_out("t4_sat",  2, 15, 1'b1, 1'b1, 1'b0);
        tick();

        // 4b: restart at cycle 9, stop at 14 -> 4 counted after restart.
        pulse_start();
        repeat (8) tick();
        pulse_start();
        repeat (4) tick();
        pulse_stop();
        expect_out("t4_restart_p4",  3, 1, 1'b0, 1'b1, 1'b0);
        expect_out("t4_restart_def", 0, 4, 1'b0, 1'b1, 1'b0);
        tick();

        // 4c: restart with prescaler mid-group; 3 counted after restart gives no tick.
        pulse_start();
        repeat (6) tick();
        pulse_start();
        repeat (3) tick();
        pulse_stop();
        expect_out("t4_pscclr_p4",  3, 0, 1'b0, 1'b1, 1'b0);
        expect_out("t4_pscclr_def", 0, 3, 1'b0, 1'b1, 1'b0);
        tick();

        // 5: stop/pause ignored in IDLE.
        stop_i = 1'b1; pause_i = 1'b1; tick(); stop_i = 1'b0; pause_i = 1'b0;
        expect_out("t5_idle_ignore", 0, 3, 1'b0, 1'b0, 1'b0);

        // 5: backpressure holds the result; start/stop ignored without ready.
        pulse_start();
        repeat (5) tick();
        ready_i = 1'b0;
        pulse_stop();
        expect_out("t5_stop_def", 0, 5, 1'b0, 1'b1, 1'b0);
        expect_out("t5_stop_w4",  1, 5, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            start_i = (k % 2 == 0);
            stop_i  = (k % 2 != 0);
            tick();
            expect_out("t5_hold", 0, 5, 1'b0, 1'b1, 1'b0);
        end
        start_i = 1'b0; stop_i = 1'b0;
        ready_i = 1'b1;
        pulse_start();
        expect_out("t5_accept_start", 0, 5, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        pulse_stop();
        expect_out("t5_new_result", 0, 2, 1'b0, 1'b1, 1'b0);
        tick();

        // 6: reset during RUN.
        pulse_start();
        repeat (3) tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        expect_out("t6_rst_run", 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("t6_rst_run_idle", 0, 0, 1'b0, 1'b0, 1'b0);

        // 6: reset during REPORT with an overflowed result pending.
        pulse_start();
        repeat (19) tick();
        ready_i = 1'b0;
        pulse_stop();
        expect_out("t6_report", 1, 3, 1'b1, 1'b1, 1'b0);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        expect_out("t6_rst_report", 1, 0, 1'b0, 1'b0, 1'b0);
        ready_i = 1'b1;
        tick();
        expect_out("t6_not_published", 1, 0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
